router_pkt_tx: RTL and testbench

Packet source for the router input port. It accepts a command (destination address and payload length) plus payload bytes from a host and buffers the whole payload internally. It then drives the router ingress protocol: a header byte and payload bytes with pkt_valid high, followed by an even-parity byte with pkt_valid low. Transfers are throttled by the router's busy signal. The block is used as the on-chip traffic source and as the stimulus block for router-level verification.

---
 rtl/router_pkt_tx.sv | 156 +++++++++++++++
 tb/tb_router_pkt_tx.sv | 465 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/router_pkt_tx.sv
// rtl/router_pkt_tx.sv - buffered packet source driving the router ingress port
module router_pkt_tx #(
  parameter int GAP_CYCLES = 2,
  parameter int MAX_LEN    = 63
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_addr,
  input  logic [5:0] cmd_len,
  input  logic       pld_valid,
  output logic       pld_ready,
  input  logic [7:0] pld_data,
  input  logic       busy,
  output logic [7:0] data_out,
  output logic       pkt_valid,
  output logic       tx_active,
  output logic       tx_done,
  output logic       addr_err
);

  // GAP counter runs 0..GAP_CYCLES-1; keep at least one bit when GAP_CYCLES is 1
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD    = 3'd1;
  localparam logic [2:0] S_HEADER  = 3'd2;
  localparam logic [2:0] S_PAYLOAD = 3'd3;
  localparam logic [2:0] S_PARITY  = 3'd4;
  localparam logic [2:0] S_GAP     = 3'd5;

  logic [2:0]       state;
  logic [1:0]       addr_q;
  logic [5:0]       len_q;
  logic [7:0]       parity;
  logic [5:0]       wr_cnt;
  logic [5:0]       rd_ptr;
  logic [GAP_W-1:0] gap_cnt;
  logic [7:0]       hdr;
  logic [7:0]       pld_mem [MAX_LEN];

  assign hdr       = {len_q, addr_q};
  assign cmd_ready = (state == S_IDLE);
  assign pld_ready = (state == S_LOAD);
  assign tx_active = (state == S_HEADER) || (state == S_PAYLOAD) || (state == S_PARITY);

  // Payload buffer write; every slot read during transmit was written during LOAD
  always_ff @(posedge clock) begin
    if (pld_valid && pld_ready) begin
      pld_mem[wr_cnt] <= pld_data;
    end
  end

  // Packet FSM: output byte registers are reloaded only on state entry or byte consumption
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_IDLE;
      addr_q    <= 2'd0;
      len_q     <= 6'd0;
      parity    <= 8'd0;
      wr_cnt    <= 6'd0;
      rd_ptr    <= 6'd0;
      gap_cnt   <= '0;
      data_out  <= 8'd0;
      pkt_valid <= 1'b0;
      tx_done   <= 1'b0;
      addr_err  <= 1'b0;
    end else begin
      tx_done  <= 1'b0;
      addr_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            addr_q <= cmd_addr;
            len_q  <= cmd_len;
            parity <= {cmd_len, cmd_addr};
            wr_cnt <= 6'd0;
            if (cmd_len != 6'd0) begin
              state <= S_LOAD;
            end else if (cmd_addr != 2'd3) begin
              state     <= S_HEADER;
              data_out  <= {cmd_len, cmd_addr};
              pkt_valid <= 1'b1;
            end else begin
              addr_err <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          if (pld_valid) begin
            parity <= parity ^ pld_data;
            wr_cnt <= wr_cnt + 6'd1;
            if (wr_cnt == len_q - 6'd1) begin
              if (addr_q != 2'd3) begin
                state     <= S_HEADER;
                data_out  <= hdr;
                pkt_valid <= 1'b1;
              end else begin
                // Invalid destination: payload is drained but never sent
                state    <= S_IDLE;
                addr_err <= 1'b1;
              end
            end
          end
        end
        S_HEADER: begin
          if (!busy) begin
            if (len_q != 6'd0) begin
              state     <= S_PAYLOAD;
              rd_ptr    <= 6'd0;
              data_out  <= pld_mem[6'd0];
              pkt_valid <= 1'b1;
            end else begin
              state     <= S_PARITY;
              data_out  <= parity;
              pkt_valid <= 1'b0;
            end
          end
        end
        S_PAYLOAD: begin
          if (!busy) begin
            if (rd_ptr == len_q - 6'd1) begin
              state     <= S_PARITY;
              data_out  <= parity;
              pkt_valid <= 1'b0;
            end else begin
              rd_ptr   <= rd_ptr + 6'd1;
              data_out <= pld_mem[rd_ptr + 6'd1];
            end
          end
        end
        S_PARITY: begin
          if (!busy) begin
            state     <= S_GAP;
            data_out  <= 8'd0;
            pkt_valid <= 1'b0;
            tx_done   <= 1'b1;
            gap_cnt   <= '0;
          end
        end
        S_GAP: begin
          if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
            state <= S_IDLE;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_router_pkt_tx.sv
// tb/tb_router_pkt_tx.sv - randomized self-checking bench for router_pkt_tx
module tb_router_pkt_tx;
  localparam int GAP = 2;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_addr = 2'd0;
  logic [5:0] cmd_len = 6'd0;
  logic       pld_valid = 1'b0;
  logic       pld_ready;
  logic [7:0] pld_data = 8'd0;
  logic       busy;
  logic [7:0] data_out;
  logic       pkt_valid;
  logic       tx_active;
  logic       tx_done;
  logic       addr_err;

  int   busy_mode = 0;
  logic busy_manual = 1'b0;
  logic busy_rand = 1'b0;
  bit   pld_gaps = 1'b0;
  assign busy = (busy_mode == 1) ? busy_rand : busy_manual;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int tx_done_cnt = 0;
  int addr_err_cnt = 0;
  int pld_ready_cnt = 0;
  int pkt_hi_cnt = 0;
  logic prev_act = 1'b0;

  logic [8:0] mon_q[$];
  logic [8:0] exp_q[$];
  int hdr_cyc_q[$];
  int par_cyc_q[$];
  logic [7:0] pay [64];

  router_pkt_tx #(.GAP_CYCLES(GAP), .MAX_LEN(63)) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .pld_valid(pld_valid), .pld_ready(pld_ready), .pld_data(pld_data),
    .busy(busy), .data_out(data_out), .pkt_valid(pkt_valid),
    .tx_active(tx_active), .tx_done(tx_done), .addr_err(addr_err)
  );

  always #5 clock = ~clock;

  // Free-running cycle counter
  always @(posedge clock) cyc <= cyc + 1;

  // Random busy pattern, changed just after each rising edge
  initial forever begin
    @(posedge clock);
    #1;
    busy_rand = ($urandom_range(0, 2) == 0);
  end

  // Record each byte the router accepts plus pulse/level counters
  always @(negedge clock) begin
    if (reset) begin
      prev_act <= 1'b0;
    end else begin
      if (tx_active && !busy) begin
        mon_q.push_back({pkt_valid, data_out});
        if (!pkt_valid) par_cyc_q.push_back(cyc);
      end
      if (tx_active && !prev_act) hdr_cyc_q.push_back(cyc);
      prev_act <= tx_active;
      if (tx_done) tx_done_cnt <= tx_done_cnt + 1;
      if (addr_err) addr_err_cnt <= addr_err_cnt + 1;
      if (pld_ready) pld_ready_cnt <= pld_ready_cnt + 1;
      if (pkt_valid) pkt_hi_cnt <= pkt_hi_cnt + 1;
    end
  end

  function automatic int first_diff();
    int n;
    n = (mon_q.size() > exp_q.size()) ? mon_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      if (i >= mon_q.size() || i >= exp_q.size()) return i;
      if (mon_q[i] !== exp_q[i]) return i;
    end
    return -1;
  endfunction

  function automatic int mon_at(input int i);
    if (i < 0 || i >= mon_q.size()) return -1;
    return int'(mon_q[i]);
  endfunction

  function automatic int exp_at(input int i);
    if (i < 0 || i >= exp_q.size()) return -1;
    return int'(exp_q[i]);
  endfunction

  // Expected wire bytes: {pkt_valid, byte}; invalid destinations send nothing
  task automatic model_pkt(input int a, input int l);
    logic [7:0] h;
    logic [7:0] p;
    if (a == 3) return;
    h = 8'(l * 4 + a);
    p = h;
    exp_q.push_back({1'b1, h});
    for (int i = 0; i < l; i++) begin
      exp_q.push_back({1'b1, pay[i]});
      p = p ^ pay[i];
    end
    exp_q.push_back({1'b0, p});
  endtask

  task automatic clear_obs();
    mon_q.delete();
    exp_q.delete();
    hdr_cyc_q.delete();
    par_cyc_q.delete();
  endtask

  task automatic fill_pay(input int l, input logic [7:0] fixed, input bit use_fixed);
    for (int i = 0; i < 64; i++) pay[i] = use_fixed ? fixed : 8'($urandom);
  endtask

  // Command handshake then payload bytes; returns just after the final accepting edge
  task automatic issue_pkt(input logic [1:0] a, input logic [5:0] l);
    int n;
    int guard;
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_len   = l;
    guard = 0;
    @(negedge clock);
    while (!cmd_ready && guard < 2000) begin
      @(negedge clock);
      guard++;
    end
    if (guard >= 2000) begin
      checks++; errors++;
      $display("FAIL issue_cmd_timeout: cmd_ready=%0b after %0d cycles, required 1", cmd_ready, guard);
    end
    @(posedge clock);
    #1;
    cmd_valid = 1'b0;
    cmd_addr  = 2'($urandom);
    cmd_len   = 6'($urandom);
    n = 0;
    guard = 0;
    while (n < int'(l) && guard < 2000) begin
      pld_valid = pld_gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      pld_data  = pay[n];
      @(negedge clock);
      if (pld_valid && pld_ready) n++;
      @(posedge clock);
      #1;
      guard++;
    end
    if (n < int'(l)) begin
      checks++; errors++;
      $display("FAIL issue_pld_timeout: accepted=%0d required=%0d", n, l);
    end
    pld_valid = 1'b0;
    pld_data  = 8'($urandom);
  endtask

  task automatic wait_tx(input int target);
    int guard;
    guard = 0;
    while (tx_done_cnt < target && guard < 3000) begin
      @(posedge clock);
      #1;
      guard++;
    end
    if (tx_done_cnt < target) begin
      checks++; errors++;
      $display("FAIL wait_tx_timeout: tx_done count=%0d required=%0d", tx_done_cnt, target);
    end
    repeat (GAP + 2) @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if ({data_out, pkt_valid, tx_active, tx_done, addr_err, pld_ready} !== 13'd0) begin
      errors++;
      $display("FAIL reset_outputs: data_out=%0h pkt_valid=%0b tx_active=%0b tx_done=%0b addr_err=%0b pld_ready=%0b, required all 0",
               data_out, pkt_valid, tx_active, tx_done, addr_err, pld_ready);
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_cmd_ready: got %0b required 1", cmd_ready);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic test_basic();
    int base;
    int d;
    busy_mode = 0; busy_manual = 1'b0; pld_gaps = 1'b0;
    clear_obs();
    base = tx_done_cnt;
    fill_pay(3, 8'd0, 1'b0);
    pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
    model_pkt(1, 3);
    issue_pkt(2'd1, 6'd3);
    wait_tx(base + 1);
    d = first_diff();
    checks++;
    if (d != -1) begin
      errors++;
      $display("FAIL basic_wire: idx %0d got %0h required %0h (sizes %0d/%0d)", d, mon_at(d), exp_at(d), mon_q.size(), exp_q.size());
    end
    checks++;
    if (mon_at(0) != 'h10D || mon_at(4) != 'h00D) begin
      errors++;
      $display("FAIL basic_hdr_par: header %0h parity %0h required 10d and 00d", mon_at(0), mon_at(4));
    end
    checks++;
    if (tx_done_cnt - base != 1) begin
      errors++;
      $display("FAIL basic_tx_done: pulses %0d required 1", tx_done_cnt - base);
    end
  endtask

  task automatic test_busy_hold();
    int base;
    int guard;
    int hold;
    int d;
    busy_mode = 0; busy_manual = 1'b0; pld_gaps = 1'b0;
    clear_obs();
    base = tx_done_cnt;
    pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
    model_pkt(1, 3);
    issue_pkt(2'd1, 6'd3);
    guard = 0;
    while (!(pkt_valid && data_out == 8'h22) && guard < 50) begin
      @(posedge clock);
      #1;
      guard++;
    end
    hold = 0;
    for (int k = 0; k < 8; k++) begin
      if (pkt_valid && data_out == 8'h22) hold++;
      busy_manual = (k < 3);
      @(posedge clock);
      #1;
    end
    busy_manual = 1'b0;
    checks++;
    if (hold != 4) begin
      errors++;
      $display("FAIL busy_hold_cycles: 0x22 held %0d cycles required 4", hold);
    end
    wait_tx(base + 1);
    d = first_diff();
    checks++;
    if (d != -1) begin
      errors++;
      $display("FAIL busy_wire: idx %0d got %0h required %0h (sizes %0d/%0d)", d, mon_at(d), exp_at(d), mon_q.size(), exp_q.size());
    end
  endtask

  task automatic test_len_zero();
    int base;
    int pr;
    int d;
    busy_mode = 0; busy_manual = 1'b0; pld_gaps = 1'b0;
    clear_obs();
    base = tx_done_cnt;
    pr = pld_ready_cnt;
    model_pkt(2, 0);
    issue_pkt(2'd2, 6'd0);
    wait_tx(base + 1);
    d = first_diff();
    checks++;
    if (d != -1) begin
      errors++;
      $display("FAIL len0_wire: idx %0d got %0h required %0h (sizes %0d/%0d)", d, mon_at(d), exp_at(d), mon_q.size(), exp_q.size());
    end
    checks++;
    if (pld_ready_cnt != pr) begin
      errors++;
      $display("FAIL len0_pld_ready: high %0d cycles required 0", pld_ready_cnt - pr);
    end
  endtask

  task automatic test_addr_err();
    int ae;
    int ph;
    busy_mode = 0; busy_manual = 1'b0; pld_gaps = 1'b0;
    clear_obs();
    ae = addr_err_cnt;
    ph = pkt_hi_cnt;
    pay[0] = 8'hAA; pay[1] = 8'h55;
    issue_pkt(2'd3, 6'd2);
    checks++;
    if (addr_err !== 1'b1 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL adderr_next: addr_err=%0b cmd_ready=%0b required 1 and 1", addr_err, cmd_ready);
    end
    repeat (5) @(posedge clock);
    #1;
    checks++;
    if (addr_err_cnt - ae != 1) begin
      errors++;
      $display("FAIL adderr_pulses: got %0d required 1", addr_err_cnt - ae);
    end
    checks++;
    if (pkt_hi_cnt != ph || mon_q.size() != 0) begin
      errors++;
      $display("FAIL adderr_silent: pkt_valid cycles %0d bytes %0d required 0 and 0", pkt_hi_cnt - ph, mon_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int base;
    int guard;
    int d;
    busy_mode = 0; busy_manual = 1'b0; pld_gaps = 1'b0;
    clear_obs();
    fill_pay(5, 8'd0, 1'b0);
    issue_pkt(2'd1, 6'd5);
    guard = 0;
    while (mon_q.size() < 2 && guard < 50) begin
      @(posedge clock);
      #1;
      guard++;
    end
    checks++;
    if (data_out !== pay[1] || pkt_valid !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_presented: data_out=%0h pkt_valid=%0b required %0h and 1", data_out, pkt_valid, pay[1]);
    end
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    checks++;
    if (pkt_valid !== 1'b0 || cmd_ready !== 1'b1 || tx_active !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_after: pkt_valid=%0b cmd_ready=%0b tx_active=%0b required 0 1 0", pkt_valid, cmd_ready, tx_active);
    end
    base = tx_done_cnt;
    clear_obs();
    repeat (10) @(posedge clock);
    #1;
    checks++;
    if (mon_q.size() != 0 || tx_done_cnt != base) begin
      errors++;
      $display("FAIL rstmid_abandon: bytes %0d tx_done %0d required 0 and 0", mon_q.size(), tx_done_cnt - base);
    end
    fill_pay(1, 8'd0, 1'b0);
    model_pkt(0, 1);
    issue_pkt(2'd0, 6'd1);
    wait_tx(base + 1);
    d = first_diff();
    checks++;
    if (d != -1) begin
      errors++;
      $display("FAIL rstmid_next: idx %0d got %0h required %0h (sizes %0d/%0d)", d, mon_at(d), exp_at(d), mon_q.size(), exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    int base;
    int l2;
    int a2;
    int d;
    busy_mode = 0; busy_manual = 1'b0; pld_gaps = 1'b0;
    clear_obs();
    base = tx_done_cnt;
    fill_pay(63, 8'hFF, 1'b1);
    model_pkt(0, 63);
    issue_pkt(2'd0, 6'd63);
    l2 = $urandom_range(1, 8);
    a2 = $urandom_range(0, 2);
    fill_pay(l2, 8'd0, 1'b0);
    model_pkt(a2, l2);
    issue_pkt(2'(a2), 6'(l2));
    wait_tx(base + 2);
    d = first_diff();
    checks++;
    if (d != -1) begin
      errors++;
      $display("FAIL b2b_wire: idx %0d got %0h required %0h (sizes %0d/%0d)", d, mon_at(d), exp_at(d), mon_q.size(), exp_q.size());
    end
    checks++;
    if (mon_at(0) != 'h1FC || mon_at(64) != 'h003) begin
      errors++;
      $display("FAIL b2b_hdr_par: header %0h parity %0h required 1fc and 003", mon_at(0), mon_at(64));
    end
    checks++;
    if (hdr_cyc_q.size() != 2 || par_cyc_q.size() != 2) begin
      errors++;
      $display("FAIL b2b_counts: headers %0d parities %0d required 2 and 2", hdr_cyc_q.size(), par_cyc_q.size());
    end else if (hdr_cyc_q[1] - par_cyc_q[0] != GAP + l2 + 2) begin
      errors++;
      $display("FAIL b2b_spacing: got %0d cycles required %0d", hdr_cyc_q[1] - par_cyc_q[0], GAP + l2 + 2);
    end
  endtask

  task automatic test_random();
    int a;
    int l;
    int base;
    int ae;
    int d;
    busy_mode = 1; pld_gaps = 1'b1;
    for (int p = 0; p < 10; p++) begin
      clear_obs();
      a = $urandom_range(0, 3);
      l = ($urandom_range(0, 5) == 0) ? 63 : $urandom_range(0, 12);
      base = tx_done_cnt;
      ae = addr_err_cnt;
      fill_pay(l, 8'd0, 1'b0);
      model_pkt(a, l);
      issue_pkt(2'(a), 6'(l));
      if (a == 3) begin
        repeat (4) @(posedge clock);
        #1;
        checks++;
        if (addr_err_cnt - ae != 1 || mon_q.size() != 0) begin
          errors++;
          $display("FAIL rand_adderr[%0d]: pulses %0d bytes %0d required 1 and 0", p, addr_err_cnt - ae, mon_q.size());
        end
      end else begin
        wait_tx(base + 1);
        d = first_diff();
        checks++;
        if (d != -1) begin
          errors++;
          $display("FAIL rand_wire[%0d]: idx %0d got %0h required %0h (sizes %0d/%0d)", p, d, mon_at(d), exp_at(d), mon_q.size(), exp_q.size());
        end
        checks++;
        if (tx_done_cnt - base != 1) begin
          errors++;
          $display("FAIL rand_tx_done[%0d]: pulses %0d required 1", p, tx_done_cnt - base);
        end
      end
    end
    busy_mode = 0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_busy_hold();
    test_len_zero();
    test_addr_err();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
